// File: rtl/mtm_alu_pkg.sv
// Shared constants and CRC4 helpers for the mtm_Alu deserializer.
// CRC4 uses polynomial x^4+x+1, MSB first, initial value 0.
package mtm_alu_pkg;

   localparam logic [2:0] OP_AND = 3'b000;
   localparam logic [2:0] OP_OR  = 3'b001;
   localparam logic [2:0] OP_ADD = 3'b100;
   localparam logic [2:0] OP_SUB = 3'b101;

   localparam logic PKT_DATA = 1'b0;
   localparam logic PKT_CTL  = 1'b1;

   localparam int unsigned ERR_DATA = 2;
   localparam int unsigned ERR_CRC  = 1;
   localparam int unsigned ERR_OP   = 0;

   typedef enum logic [1:0] {PIdle, PBits, PStop} pkt_state_e;
   typedef enum logic       {FIdle, FRecv}        frame_state_e;

   function automatic logic [3:0] crc4_next(input logic [3:0] crc, input logic b);
      logic fb;
      fb = crc[3] ^ b;
      return {crc[2:0], 1'b0} ^ {2'b00, fb, fb};
   endfunction

   function automatic logic [3:0] crc4_byte(input logic [3:0] crc, input logic [7:0] data);
      logic [3:0] c;
      c = crc;
      for (int i = 7; i >= 0; i--) begin
         c = crc4_next(c, data[i]);
      end
      return c;
   endfunction

   function automatic logic op_valid(input logic [2:0] op);
      return (op == OP_AND) || (op == OP_OR) || (op == OP_ADD) || (op == OP_SUB);
   endfunction

endpackage

// File: rtl/mtm_alu_pkt_rx.sv
// Bit-level receiver for 11-bit packets: start, type, d[7:0] MSB first, stop.
// o_idle is present only when MTM_DES_TIMEOUT_EN is defined.
module mtm_alu_pkt_rx
   import mtm_alu_pkg::*;
(
   input  logic       i_clk,
   input  logic       i_rst,
   input  logic       i_sin,
`ifdef MTM_DES_TIMEOUT_EN
   output logic       o_idle,
`endif
   output logic       o_pkt_valid,
   output logic       o_pkt_type,
   output logic [7:0] o_pkt_data,
   output logic       o_pkt_frame_err
);

   pkt_state_e r_state, w_state_next;
   logic [3:0] r_cnt;
   logic [8:0] r_shift;

   always_ff @(posedge i_clk) begin
      if (i_rst) r_state <= PIdle;
      else       r_state <= w_state_next;
   end

   always_comb begin
      w_state_next = r_state;
      unique case (r_state)
         PIdle:   if (!i_sin) w_state_next = PBits;
         PBits:   if (r_cnt == 4'd8) w_state_next = PStop;
         PStop:   w_state_next = PIdle;
         default: w_state_next = PIdle;
      endcase
   end

   // Type bit lands in r_shift[8], data byte in r_shift[7:0].
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_cnt   <= '0;
         r_shift <= '0;
      end else if (r_state == PBits) begin
         r_shift <= {r_shift[7:0], i_sin};
         r_cnt   <= r_cnt + 4'd1;
      end else begin
         r_cnt   <= '0;
      end
   end

   always_comb begin
      o_pkt_valid     = (r_state == PStop) && i_sin;
      o_pkt_frame_err = (r_state == PStop) && !i_sin;
      o_pkt_type      = r_shift[8];
      o_pkt_data      = r_shift[7:0];
   end

`ifdef MTM_DES_TIMEOUT_EN
   assign o_idle = (r_state == PIdle);
`endif

endmodule

// File: rtl/mtm_alu_deserializer.sv
// mtm_Alu input stage: assembles 8 DATA + 1 CTL packets into a checked command.
// Define MTM_DES_TIMEOUT_EN to abort frames that stall between packets.
module mtm_alu_deserializer
   import mtm_alu_pkg::*;
#(
   parameter int unsigned N_DATA_PKTS = 8
`ifdef MTM_DES_TIMEOUT_EN
   , parameter int unsigned TIMEOUT_CYCLES = 64
`endif
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        sin,
   output logic        out_valid,
   input  logic        out_ready,
   output logic [31:0] out_a,
   output logic [31:0] out_b,
   output logic [2:0]  out_op,
   output logic [2:0]  out_err
);

   localparam int unsigned     CntW  = $clog2(N_DATA_PKTS + 1);
   localparam logic [CntW-1:0] NPkts = CntW'(N_DATA_PKTS);

   logic       w_pkt_valid, w_pkt_type, w_pkt_frame_err;
   logic [7:0] w_pkt_data;
`ifdef MTM_DES_TIMEOUT_EN
   logic       w_rx_idle;
`endif

   mtm_alu_pkt_rx u_pkt_rx (
      .i_clk           (clk),
      .i_rst           (rst),
      .i_sin           (sin),
`ifdef MTM_DES_TIMEOUT_EN
      .o_idle          (w_rx_idle),
`endif
      .o_pkt_valid     (w_pkt_valid),
      .o_pkt_type      (w_pkt_type),
      .o_pkt_data      (w_pkt_data),
      .o_pkt_frame_err (w_pkt_frame_err)
   );

   frame_state_e    r_fstate, w_fstate_next;
   logic [CntW-1:0] r_count;
   logic [63:0]     r_shift;
   logic [3:0]      r_crc;
   logic            r_data_err;

   logic       w_data_ev, w_ctl_ev, w_abort_ev, w_timeout;
   logic       w_done;
   logic [2:0] w_err;
   logic [3:0] w_crc_exp;

   assign w_data_ev  = w_pkt_valid && (w_pkt_type == PKT_DATA);
   assign w_ctl_ev   = w_pkt_valid && (w_pkt_type == PKT_CTL);
   assign w_abort_ev = w_pkt_frame_err || w_timeout;

   always_ff @(posedge clk) begin
      if (rst) r_fstate <= FIdle;
      else     r_fstate <= w_fstate_next;
   end

   always_comb begin
      w_fstate_next = r_fstate;
      unique case (r_fstate)
         FIdle:   if (w_data_ev) w_fstate_next = FRecv;
         FRecv:   if (w_ctl_ev || w_abort_ev) w_fstate_next = FIdle;
         default: w_fstate_next = FIdle;
      endcase
   end

   // Result of a completing frame; the CRC continues over {1'b1, OP}.
   always_comb begin
      w_crc_exp = crc4_next(r_crc, 1'b1);
      for (int i = 2; i >= 0; i--) begin
         w_crc_exp = crc4_next(w_crc_exp, w_pkt_data[4+i]);
      end
      w_done = w_ctl_ev || w_abort_ev;
      w_err  = '0;
      if (w_abort_ev) begin
         w_err[ERR_DATA] = 1'b1;
      end else if (w_ctl_ev) begin
         if ((r_count != NPkts) || r_data_err || w_pkt_data[7]) w_err[ERR_DATA] = 1'b1;
         else if (w_crc_exp != w_pkt_data[3:0])                 w_err[ERR_CRC]  = 1'b1;
         else if (!op_valid(w_pkt_data[6:4]))                    w_err[ERR_OP]   = 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_count    <= '0;
         r_shift    <= '0;
         r_crc      <= '0;
         r_data_err <= 1'b0;
      end else if (w_done) begin
         r_count    <= '0;
         r_crc      <= '0;
         r_data_err <= 1'b0;
      end else if (w_data_ev) begin
         if (r_count < NPkts) begin
            r_shift <= {r_shift[55:0], w_pkt_data};
            r_count <= r_count + 1'b1;
            r_crc   <= crc4_byte(r_crc, w_pkt_data);
         end else begin
            r_data_err <= 1'b1;
         end
      end
   end

`ifdef MTM_DES_TIMEOUT_EN
   localparam int unsigned      IdleW    = $clog2(TIMEOUT_CYCLES + 1);
   localparam logic [IdleW-1:0] IdleLast = IdleW'(TIMEOUT_CYCLES - 1);

   logic [IdleW-1:0] r_idle;
   logic             w_idle_tick;

   // A start bit (sin=0 while the receiver is idle) breaks the idle run.
   assign w_idle_tick = (r_fstate == FRecv) && w_rx_idle && sin;
   assign w_timeout   = w_idle_tick && (r_idle == IdleLast);

   always_ff @(posedge clk) begin
      if (rst || !w_idle_tick || w_timeout) r_idle <= '0;
      else                                  r_idle <= r_idle + 1'b1;
   end
`else
   assign w_timeout = 1'b0;
`endif

   logic        r_valid;
   logic [31:0] r_a, r_b;
   logic [2:0]  r_op, r_err;

   // A result completing while one is still held and not being accepted is dropped.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_valid <= 1'b0;
         r_a     <= '0;
         r_b     <= '0;
         r_op    <= '0;
         r_err   <= '0;
      end else begin
         if (r_valid && out_ready) r_valid <= 1'b0;
         if (w_done && (!r_valid || out_ready)) begin
            r_valid <= 1'b1;
            r_err   <= w_err;
            if (w_err == 3'b000) begin
               r_a  <= r_shift[31:0];
               r_b  <= r_shift[63:32];
               r_op <= w_pkt_data[6:4];
            end else begin
               r_a  <= '0;
               r_b  <= '0;
               r_op <= '0;
            end
         end
      end
   end

   assign out_valid = r_valid;
   assign out_a     = r_a;
   assign out_b     = r_b;
   assign out_op    = r_op;
   assign out_err   = r_err;

endmodule

// File: doc/mtm_alu_deserializer.md
Name: mtm_alu_deserializer

Overview:
- Input stage of mtm_Alu. Sits between the serial line `sin` and the ALU core.
- Frames 11-bit serial packets and assembles one command: 8 DATA packets followed by 1 CTL packet.
- Checks packet count, CRC4 and opcode, then presents operands A and B, the opcode and an error code to the core over a valid/ready handshake.

Parameters:
- N_DATA_PKTS, 8, number of DATA packets per frame; the first 4 carry B, the next 4 carry A, each MSB byte first.
- TIMEOUT_CYCLES, 64, idle cycles allowed between packets of a frame; used only when MTM_DES_TIMEOUT_EN is defined.

Ports:
- clk  in  1  system clock; all logic samples on the rising edge.
- rst  in  1  synchronous reset, active-high.
- sin  in  1  serial input, one bit per clk, idles at 1.
- out_valid  out  1  command or error result is available.
- out_ready  in  1  core accepts the result.
- out_a  out  32  operand A.
- out_b  out  32  operand B.
- out_op  out  3  opcode: AND=000, OR=001, ADD=100, SUB=101.
- out_err  out  3  {ERR_DATA, ERR_CRC, ERR_OP}, one-hot, or 000 when there is no error.

Behaviour:
- Reset: out_valid=0, out_a=0, out_b=0, out_op=0, out_err=0. Packet and frame FSMs go to IDLE; data count=0; CRC accumulator=0.
- Packet format, bit order on the line: start(0), type(0=DATA, 1=CTL), d[7:0] MSB first, stop(1). Total 11 bits.
- Packet FSM states:
  - P_IDLE: wait for sin=0; that bit is taken as the start bit.
  - P_BITS: 4-bit counter captures type + 8 data bits.
  - P_STOP: checks the stop bit, then returns to P_IDLE.
  - Back-to-back packets, with the start bit immediately after a stop bit, are supported.
- Stop bit = 0: packet discarded; the frame is aborted with ERR_DATA.
- DATA packet:
  - If count < N_DATA_PKTS: shift the byte into {B,A}, increment count, fold the byte into CRC4.
  - Otherwise: set the sticky data_err flag.
- CTL packet: byte = {0, OP[2:0], CRC[3:0]}.
  - CRC4 uses polynomial x^4+x+1, initial value 0, computed over {B, A, 1'b1, OP}, 68 bits MSB first.
  - Error priority, exactly one flag:
    1. ERR_DATA if count != N_DATA_PKTS, data_err is set, or CTL bit7 = 1.
    2. ERR_CRC on CRC mismatch.
    3. ERR_OP if OP is not in {000, 001, 100, 101}.
  - After any CTL packet: count, CRC accumulator and data_err are cleared.
- Latency: out_valid rises on the cycle after the CTL stop bit is sampled.
  - out_a, out_b and out_op hold the received values.
  - On an error result, out_a, out_b and out_op are 0.
- Handshake:
  - out_valid stays high with all outputs stable until a cycle with out_valid & out_ready; it drops on the next edge.
  - A new frame can complete in the same cycle as acceptance; the new result loads and out_valid stays 1.
  - A frame that completes while the previous result is still unaccepted is dropped silently. The held result is not overwritten.
- Reset mid-packet or mid-frame discards all partial state. No result is produced for that frame.

Optional Feature:
- MTM_DES_TIMEOUT_EN.
- Defined:
  - An idle counter runs while count > 0 and the packet FSM is in P_IDLE.
  - When it reaches TIMEOUT_CYCLES, the frame is aborted and emits an ERR_DATA result under the normal handshake rules.
  - The counter clears on every start bit.
- Not defined: no counter is built. A partial frame waits indefinitely for its CTL packet.

Decomposition:
- Package mtm_alu_pkg holds:
  - opcode constants OP_AND, OP_OR, OP_ADD, OP_SUB;
  - packet type constants PKT_DATA, PKT_CTL;
  - error bit indices ERR_DATA=2, ERR_CRC=1, ERR_OP=0;
  - function crc4_next(crc, bit), plus a byte-wide wrapper.
- Sub-module mtm_alu_pkt_rx: the bit-level packet FSM.
  - Outputs pkt_valid (1-cycle pulse), pkt_type, pkt_data[7:0] and pkt_frame_err.
  - The frame FSM stays in the top level.

Test Plan:
- Send B=0x00000000, A=0xFFFFFFFF, OP=000 with correct CRC; out_ready held 1 -> out_valid for 1 cycle, 1 cycle after the CTL stop bit; out_a=0xFFFFFFFF, out_b=0, out_op=000, out_err=000. Repeat for OP 001, 100 and 101, and with A/B swapped.
- Send 7 DATA packets + CTL -> out_err=100, out_a=out_b=0. Send 9 DATA packets + CTL -> out_err=100.
- Send a valid frame with the CRC field XOR 4'b0001 -> out_err=010. Send a valid frame with OP=010 and correct CRC -> out_err=001.
- Hold out_ready=0 while sending two valid frames -> first result held stable and second dropped; raise out_ready -> exactly one acceptance.
- Assert rst after 4 DATA packets, release, send a full valid frame -> exactly one correct result, with no residue from the aborted frame.
- With MTM_DES_TIMEOUT_EN and TIMEOUT_CYCLES=64: send 3 DATA packets, then idle 64 cycles -> out_err=100. Then send a valid frame -> correct result.
